// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and reports all-ones quotient with DivZero.
module divider_seq #(
    parameter int n = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] Q,
    output logic [n-1:0] R,
    output logic         Done,
    output logic         Busy,
    output logic         DivZero
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  count;
    logic [n-1:0]   dividend;
    logic [n-1:0]   divisor;
    logic [n:0]     rem;
    logic [n:0]     rem_shift;
    logic [n+1:0]   trial;
    logic           q_bit;
    logic [n:0]     rem_next;
    logic           last_step;

    // The dividend register doubles as the quotient register: each step shifts
    // one dividend bit out of the top and one quotient bit in at the bottom.
    always_comb begin
        rem_shift = {rem[n-1:0], dividend[n-1]};
        trial     = {1'b0, rem_shift} - {2'b00, divisor};
        q_bit     = rem[n] | ~trial[n+1];
        rem_next  = q_bit ? trial[n:0] : rem_shift;
        last_step = (count == CW'(1));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    next_state = (B == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            count    <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            Q        <= '0;
            R        <= '0;
            DivZero  <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state <= next_state;
            Done  <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (Start) begin
                        dividend <= A;
                        divisor  <= B;
                        rem      <= '0;
                        count    <= CW'(n);
                        if (B == '0) begin
                            Q       <= '1;
                            R       <= A;
                            DivZero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem      <= rem_next;
                    dividend <= {dividend[n-2:0], q_bit};
                    count    <= count - 1'b1;
                    if (last_step) begin
                        Q       <= {dividend[n-2:0], q_bit};
                        R       <= rem_next[n-1:0];
                        DivZero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed corner cases plus random
// operands compared against plain integer division.
module tb_divider_seq;

    localparam int N  = 16;
    localparam int TO = N + 6;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         Done;
    logic         Busy;
    logic         DivZero;

    int testsRun  = 0;
    int failCount = 0;

    always #5 Clock = ~Clock;

    divider_seq #(.n(N)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Q       (Q),
        .R       (R),
        .Done    (Done),
        .Busy    (Busy),
        .DivZero (DivZero)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepEdge();
        @(posedge Clock);
        #1;
    endtask

    // Runs one division from IDLE; intrudeAt >= 0 pulses a competing Start mid-run.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input int intrudeAt);
        int           lat;
        int           busyCnt;
        int           expLat;
        logic [N-1:0] expQ;
        logic [N-1:0] expR;
        logic         expDz;
        lat     = 0;
        busyCnt = 0;
        if (b == '0) begin
            expQ   = '1;
            expR   = a;
            expDz  = 1'b1;
            expLat = 0;
        end else begin
            expQ   = a / b;
            expR   = a % b;
            expDz  = 1'b0;
            expLat = N;
        end
        A     = a;
        B     = b;
        Start = 1'b1;
        stepEdge();
        Start = 1'b0;
        A     = N'($urandom);
        B     = N'($urandom);
        while (Done !== 1'b1 && lat < TO) begin
            if (Busy === 1'b1) busyCnt++;
            Start = (lat == intrudeAt);
            if (lat == intrudeAt) begin
                A = N'(9);
                B = N'(3);
            end
            stepEdge();
            lat++;
        end
        Start = 1'b0;
        if (Busy === 1'b1) busyCnt++;
        checkOutput("doneLatency", lat, expLat);
        checkOutput("busyCycles", busyCnt, expLat + 1);
        checkOutput("quotient", Q, expQ);
        checkOutput("remainder", R, expR);
        checkOutput("divZero", DivZero, expDz);
        stepEdge();
        checkOutput("donePulseWidth", Done, 0);
        checkOutput("idleBusy", Busy, 0);
        checkOutput("holdQ", Q, expQ);
        checkOutput("holdR", R, expR);
    endtask

    initial begin
        int           lat;
        int           gap;
        int           doneSeen;
        int           sel;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        Reset = 1'b1;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        @(negedge Clock);
        repeat (2) stepEdge();
        checkOutput("resetQ", Q, 0);
        checkOutput("resetR", R, 0);
        checkOutput("resetDone", Done, 0);
        checkOutput("resetBusy", Busy, 0);
        checkOutput("resetDivZero", DivZero, 0);

        Start = 1'b1;
        A     = N'(100);
        B     = N'(7);
        stepEdge();
        checkOutput("resetBeatsStart", Busy, 0);
        Reset = 1'b0;
        Start = 1'b0;
        stepEdge();

        applyStimulus(N'(100), N'(7), -1);
        applyStimulus(N'(16'hFFFF), N'(1), -1);
        applyStimulus(N'(16'hFFFF), N'(16'hFFFF), -1);
        applyStimulus(N'(3), N'(9), -1);
        applyStimulus(N'(0), N'(5), -1);
        applyStimulus(N'(5), N'(0), -1);
        applyStimulus(N'(100), N'(7), -1);
        applyStimulus(N'(100), N'(7), 5);

        for (int i = 0; i < 24; i++) begin
            ra  = N'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0)      rb = '0;
            else if (sel == 1) rb = N'($urandom_range(1, 15));
            else               rb = N'($urandom);
            applyStimulus(ra, rb, -1);
        end

        A     = N'(1234);
        B     = N'(7);
        Start = 1'b1;
        stepEdge();
        Start = 1'b0;
        repeat (8) stepEdge();
        Reset = 1'b1;
        stepEdge();
        Reset = 1'b0;
        checkOutput("midResetQ", Q, 0);
        checkOutput("midResetR", R, 0);
        checkOutput("midResetDone", Done, 0);
        checkOutput("midResetBusy", Busy, 0);
        checkOutput("midResetDivZero", DivZero, 0);
        doneSeen = 0;
        for (int i = 0; i < TO; i++) begin
            stepEdge();
            if (Done === 1'b1) doneSeen++;
        end
        checkOutput("abortedNoDone", doneSeen, 0);

        A     = N'(100);
        B     = N'(7);
        Start = 1'b1;
        lat   = 0;
        while (Done !== 1'b1 && lat < TO) begin
            stepEdge();
            lat++;
        end
        checkOutput("heldFirstDone", Done, 1);
        gap = 0;
        do begin
            stepEdge();
            gap++;
        end while (Done !== 1'b1 && gap < 3 * N);
        checkOutput("heldDoneSpacing", gap, N + 2);
        checkOutput("heldQ", Q, 14);
        checkOutput("heldR", R, 2);
        Start = 1'b0;
        repeat (3) stepEdge();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
